mips_hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB registers by generating write enables, bubbles and flushes.
- Generates EX-stage forwarding selects.
- Owns a data-memory wait FSM with timeout detection and a stall-cycle performance counter.

---
 rtl/mips_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_mips_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: stage enables, bubbles,
// flushes, EX forwarding selects, data-memory wait tracking and stall counting.
module mips_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             MemReadEX,
  input  logic [4:0]       RtEX,
  input  logic [4:0]       RsEX,
  input  logic [4:0]       RsID,
  input  logic [4:0]       RtID,
  input  logic             BranchTakenID,
  input  logic             DmemReq,
  input  logic             DmemReady,
  input  logic             RegWriteMEM,
  input  logic [4:0]       RdMEM,
  input  logic             RegWriteWB,
  input  logic [4:0]       RdWB,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXWrite,
  output logic             IDEXBubble,
  output logic             EXMEMWrite,
  output logic             MEMWBBubble,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             TimeoutErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic memhold;
  logic loaduse;

  assign memhold = DmemReq & ~DmemReady;
  assign loaduse = MemReadEX & (RtEX != 5'd0) & ((RtEX == RsID) | (RtEX == RtID));

  // The RUN rules apply in every state; state only tracks the wait counter.
  // Outputs are held at their idle defaults while reset is asserted.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMWrite  = 1'b1;
    MEMWBBubble = 1'b0;
    ForwardA    = 2'b00;
    ForwardB    = 2'b00;
    if (RST_N) begin
      if (memhold) begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEXWrite   = 1'b0;
        EXMEMWrite  = 1'b0;
        MEMWBBubble = 1'b1;
      end else if (loaduse) begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
      end else if (BranchTakenID) begin
        IFIDFlush = 1'b1;
      end

      if (RegWriteMEM && RdMEM != 5'd0 && RdMEM == RsEX)
        ForwardA = 2'b10;
      else if (RegWriteWB && RdWB != 5'd0 && RdWB == RsEX)
        ForwardA = 2'b01;

      if (RegWriteMEM && RdMEM != 5'd0 && RdMEM == RtEX)
        ForwardB = 2'b10;
      else if (RegWriteWB && RdWB != 5'd0 && RdWB == RtEX)
        ForwardB = 2'b01;
    end
  end

  always_comb begin
    state_d       = RUN;
    wait_cnt_d    = '0;
    timeout_err_d = timeout_err_q;
    stall_cnt_d   = stall_cnt_q;

    if (memhold) begin
      state_d = MEMWAIT;
      if (state_q == MEMWAIT)
        wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WCNT_W'(1);
      else
        wait_cnt_d = WCNT_W'(1);
      if (wait_cnt_d == WAIT_MAX)
        timeout_err_d = 1'b1;
    end else if (loaduse) begin
      state_d = LDSTALL;
    end

    if (!PCWrite && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign TimeoutErr = timeout_err_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed-vector bench for mips_hazard_ctrl with hand-computed expectations.
module tb_mips_hazard_ctrl;

  localparam int MEM_TIMEOUT = 64;
  localparam int CNT_W       = 16;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             MemReadEX, BranchTakenID, DmemReq, DmemReady;
  logic             RegWriteMEM, RegWriteWB;
  logic [4:0]       RtEX, RsEX, RsID, RtID, RdMEM, RdWB;
  logic             PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble;
  logic             EXMEMWrite, MEMWBBubble, TimeoutErr;
  logic [1:0]       ForwardA, ForwardB;
  logic [CNT_W-1:0] StallCount;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mips_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .MemReadEX(MemReadEX), .RtEX(RtEX), .RsEX(RsEX), .RsID(RsID), .RtID(RtID),
    .BranchTakenID(BranchTakenID), .DmemReq(DmemReq), .DmemReady(DmemReady),
    .RegWriteMEM(RegWriteMEM), .RdMEM(RdMEM), .RegWriteWB(RegWriteWB), .RdWB(RdWB),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXWrite(IDEXWrite), .IDEXBubble(IDEXBubble), .EXMEMWrite(EXMEMWrite),
    .MEMWBBubble(MEMWBBubble), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .TimeoutErr(TimeoutErr), .StallCount(StallCount)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    MemReadEX = 0; BranchTakenID = 0; DmemReq = 0; DmemReady = 0;
    RegWriteMEM = 0; RegWriteWB = 0;
    RtEX = 0; RsEX = 0; RsID = 0; RtID = 0; RdMEM = 0; RdWB = 0;
  endtask

  task automatic check_freeze(input string tag);
    check_val({tag, "_pc"},    32'(PCWrite), 0);
    check_val({tag, "_ifid"},  32'(IFIDWrite), 0);
    check_val({tag, "_idex"},  32'(IDEXWrite), 0);
    check_val({tag, "_exmem"}, 32'(EXMEMWrite), 0);
    check_val({tag, "_mwbub"}, 32'(MEMWBBubble), 1);
  endtask

  initial begin
    RST_N = 0;
    idle_inputs();
    tick();
    tick();
    RST_N = 1;
    #1;

    // Reset state
    check_val("rst_pc", 32'(PCWrite), 1);
    check_val("rst_exmem", 32'(EXMEMWrite), 1);
    check_val("rst_bub", 32'(IDEXBubble), 0);
    check_val("rst_terr", 32'(TimeoutErr), 0);
    check_val("rst_cnt", 32'(StallCount), 0);

    // Load-use on rs: exactly one stall cycle
    MemReadEX = 1; RtEX = 8; RsID = 8; #1;
    check_val("lu_pc", 32'(PCWrite), 0);
    check_val("lu_ifid", 32'(IFIDWrite), 0);
    check_val("lu_bub", 32'(IDEXBubble), 1);
    check_val("lu_idexw", 32'(IDEXWrite), 1);
    tick();
    MemReadEX = 0; #1;
    check_val("lu_next_pc", 32'(PCWrite), 1);
    check_val("lu_next_bub", 32'(IDEXBubble), 0);
    check_val("lu_cnt", 32'(StallCount), 1);
    tick();
    check_val("lu_cnt_hold", 32'(StallCount), 1);

    // Load to $0 is not a hazard
    MemReadEX = 1; RtEX = 0; RsID = 0; RtID = 0; #1;
    check_val("ld0_pc", 32'(PCWrite), 1);
    check_val("ld0_bub", 32'(IDEXBubble), 0);
    tick();
    check_val("ld0_cnt", 32'(StallCount), 1);
    idle_inputs();

    // Memory wait: 3 frozen cycles then release
    DmemReq = 1; DmemReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_freeze($sformatf("mw%0d", i));
      tick();
    end
    DmemReady = 1; #1;
    check_val("mw_rel_pc", 32'(PCWrite), 1);
    check_val("mw_rel_exmem", 32'(EXMEMWrite), 1);
    check_val("mw_rel_mwbub", 32'(MEMWBBubble), 0);
    tick();
    check_val("mw_cnt", 32'(StallCount), 4);
    check_val("mw_terr", 32'(TimeoutErr), 0);
    idle_inputs();

    // Asynchronous reset in the middle of a memory wait (counter at 5)
    DmemReq = 1; DmemReady = 0;
    RegWriteMEM = 1; RdMEM = 5; RsEX = 5;
    for (int i = 0; i < 5; i++) tick();
    #2;
    RST_N = 0; #1;
    check_val("arst_pc", 32'(PCWrite), 1);
    check_val("arst_exmem", 32'(EXMEMWrite), 1);
    check_val("arst_mwbub", 32'(MEMWBBubble), 0);
    check_val("arst_fwda", 32'(ForwardA), 0);
    check_val("arst_terr", 32'(TimeoutErr), 0);
    check_val("arst_cnt", 32'(StallCount), 0);
    tick();
    idle_inputs();
    RST_N = 1; #1;
    tick();
    check_val("arst_post_cnt", 32'(StallCount), 0);

    // Timeout: MEM_TIMEOUT + 2 stalled cycles
    DmemReq = 1; DmemReady = 0;
    for (int i = 1; i <= MEM_TIMEOUT + 2; i++) begin
      tick();
      if (i == MEM_TIMEOUT - 1) check_val("to_before", 32'(TimeoutErr), 0);
      if (i == MEM_TIMEOUT)     check_val("to_at", 32'(TimeoutErr), 1);
    end
    check_freeze("to_still");
    DmemReady = 1; #1;
    check_val("to_rel_pc", 32'(PCWrite), 1);
    tick();
    check_val("to_sticky", 32'(TimeoutErr), 1);
    check_val("to_cnt", 32'(StallCount), MEM_TIMEOUT + 2);
    idle_inputs();
    #1;

    // Forwarding priority and $0 exclusion
    RegWriteMEM = 1; RdMEM = 5; RegWriteWB = 1; RdWB = 5; RsEX = 5; RtEX = 5; #1;
    check_val("fw_mem_a", 32'(ForwardA), 2);
    check_val("fw_mem_b", 32'(ForwardB), 2);
    RegWriteMEM = 0; #1;
    check_val("fw_wb_a", 32'(ForwardA), 1);
    check_val("fw_wb_b", 32'(ForwardB), 1);
    RegWriteMEM = 1; RdMEM = 3; RsEX = 3; RdWB = 4; RtEX = 4; #1;
    check_val("fw_mix_a", 32'(ForwardA), 2);
    check_val("fw_mix_b", 32'(ForwardB), 1);
    RdMEM = 0; RsEX = 0; RdWB = 0; RtEX = 0; #1;
    check_val("fw_r0_a", 32'(ForwardA), 0);
    check_val("fw_r0_b", 32'(ForwardB), 0);
    idle_inputs();
    tick();

    // Load-use on rt coincident with a taken branch
    MemReadEX = 1; RtEX = 9; RtID = 9; BranchTakenID = 1; #1;
    check_val("lub_flush", 32'(IFIDFlush), 0);
    check_val("lub_pc", 32'(PCWrite), 0);
    check_val("lub_bub", 32'(IDEXBubble), 1);
    tick();
    MemReadEX = 0; #1;
    check_val("lub_next_flush", 32'(IFIDFlush), 1);
    check_val("lub_next_pc", 32'(PCWrite), 1);
    tick();
    check_val("lub_cnt", 32'(StallCount), MEM_TIMEOUT + 3);
    idle_inputs();

    // Back-to-back load-use remains stalled out of LDSTALL
    MemReadEX = 1; RtEX = 7; RsID = 7; #1;
    tick();
    RtEX = 6; RtID = 6; RsID = 1; #1;
    check_val("b2b_pc", 32'(PCWrite), 0);
    tick();
    MemReadEX = 0; #1;
    check_val("b2b_rel_pc", 32'(PCWrite), 1);
    check_val("b2b_cnt", 32'(StallCount), MEM_TIMEOUT + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
